// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and helpers for the multi-port register file
package regfile_pkg;
  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int REG_ZERO     = 0;
  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits, busy lookup and pending popcount
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int ADDR_W   = addr_w(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [ADDR_W:0]          pend_cnt
);
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [ADDR_W:0]     pend_cnt_q, pend_cnt_d;
  // claim beats writeback on the same register; register zero is never pending
  always_comb begin
    pend_d = pend_q;
    pend_cnt_d = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      pend_d[r] = (claim_en && claim_addr == ADDR_W'(r)) ? 1'b1 :
                  (wr_en && wr_addr == ADDR_W'(r)) ? 1'b0 : pend_q[r];
      pend_cnt_d = pend_cnt_d + (ADDR_W+1)'(pend_d[r]);
    end
    pend_d[REG_ZERO] = 1'b0;
  end
  // pending bits and their count advance together so the count matches post-update state
  always_ff @(posedge clk) begin
    pend_q     <= rst ? '0 : pend_d;
    pend_cnt_q <= rst ? '0 : pend_cnt_d;
  end
  assign pend_cnt = pend_cnt_q;
  for (genvar p = 0; p < NUM_RD; p++) begin : g_busy
    logic [ADDR_W-1:0] ra;
    assign ra = rd_addr[p*ADDR_W +: ADDR_W];
    assign rd_busy[p] = pend_q[ra] && !(wr_en && wr_addr == ra);
  end
endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-read-port register file with write bypass, zero register and pending scoreboard
module regfile_mp_sb import regfile_pkg::*; #(
  parameter  int DATA_W     = DATA_W_DEF,
  parameter  int NUM_REGS   = NUM_REGS_DEF,
  parameter  int NUM_RD     = 2,
  parameter  int INIT_INDEX = 1,
  localparam int ADDR_W     = addr_w(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic [ADDR_W:0]          pend_cnt
);
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_ok;
  assign wr_ok = wr_en && wr_addr != ADDR_W'(REG_ZERO);
  // writeback port; writes to register zero are dropped
  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[wr_addr] = wr_data;
  end
  // storage with reset image of either the register index or zero
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++)
      regs_q[i] <= rst ? (INIT_INDEX != 0 ? DATA_W'(i) : '0) : regs_d[i];
  end
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = rd_addr[p*ADDR_W +: ADDR_W];
    assign rd_data[p*DATA_W +: DATA_W] = (ra == ADDR_W'(REG_ZERO)) ? '0 :
                                         (wr_en && wr_addr == ra) ? wr_data : regs_q[ra];
  end
  regfile_scoreboard #(.NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .ADDR_W(ADDR_W)) u_sb (
    .clk(clk),
    .rst(rst),
    .claim_en(claim_en),
    .claim_addr(claim_addr),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .rd_addr(rd_addr),
    .rd_busy(rd_busy),
    .pend_cnt(pend_cnt)
  );
endmodule
